// File: rtl/rs_wakeup_queue.sv
// rtl/rs_wakeup_queue.sv - reservation-station wakeup queue with CDB capture and oldest-ready issue
//
// Holds up to DEPTH dispatched instructions. Missing operands are captured from an
// N-wide common data bus by ROB tag, including in the allocation cycle itself.
// The oldest fully ready entry is presented for issue.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   flush           discard every entry; concurrent alloc/issue are ignored
//   alloc_*         dispatch side: valid/ready handshake, payload, operand values, tags, ready bits
//   cdb_*           per-channel broadcast valid, ROB tag and value
//   issue_*         functional-unit side: valid/ready handshake, payload and operands
//   count           number of occupied entries
module rs_wakeup_queue #(
  parameter int DEPTH      = 4,
  parameter int CDB_SIZE   = 2,
  parameter int N_OPERANDS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [PAYLOAD_W-1:0]             alloc_payload,
  input  logic [N_OPERANDS*DATA_WIDTH-1:0] alloc_opnd,
  input  logic [N_OPERANDS*TAG_WIDTH-1:0]  alloc_tag,
  input  logic [N_OPERANDS-1:0]            alloc_rdy,
  input  logic [CDB_SIZE-1:0]              cdb_valid,
  input  logic [CDB_SIZE*TAG_WIDTH-1:0]    cdb_tag,
  input  logic [CDB_SIZE*DATA_WIDTH-1:0]   cdb_value,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [PAYLOAD_W-1:0]             issue_payload,
  output logic [N_OPERANDS*DATA_WIDTH-1:0] issue_opnd,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0]                 valid;
  logic [PAYLOAD_W-1:0]             pay   [DEPTH];
  logic [N_OPERANDS*DATA_WIDTH-1:0] opnd  [DEPTH];
  logic [N_OPERANDS*TAG_WIDTH-1:0]  tag   [DEPTH];
  logic [N_OPERANDS-1:0]            rdy   [DEPTH];
  // older[i][j] = 1 means entry i was allocated before entry j
  logic [DEPTH-1:0]                 older [DEPTH];

  logic [DEPTH-1:0]                 ready_all;
  logic [DEPTH-1:0]                 sel;
  logic [DEPTH-1:0]                 alloc_oh;
  logic                             slot_found;
  logic                             alloc_fire;
  logic                             issue_fire;
  logic [N_OPERANDS-1:0]            wk_hit [DEPTH];
  logic [N_OPERANDS*DATA_WIDTH-1:0] wk_val [DEPTH];
  logic [N_OPERANDS-1:0]            bp_hit;
  logic [N_OPERANDS*DATA_WIDTH-1:0] bp_val;

  assign alloc_ready = (count != FULL);
  assign issue_valid = |ready_all;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign issue_fire  = issue_valid & issue_ready & ~flush;

  // Oldest-ready select: an entry wins when no other ready entry is older than it.
  always_comb begin
    ready_all = '0;
    sel       = '0;
    for (int d = 0; d < DEPTH; d++) begin
      ready_all[d] = valid[d] & (&rdy[d]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready_all[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready_all[j] && older[j][i]) begin
          sel[i] = 1'b0;
        end
      end
    end
  end

  // Mask-and-OR output mux; zero when nothing is selected.
  always_comb begin
    issue_payload = '0;
    issue_opnd    = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (sel[d]) begin
        issue_payload = issue_payload | pay[d];
        issue_opnd    = issue_opnd | opnd[d];
      end
    end
  end

  // Lowest-index free slot, one-hot. Uses registered valid, so a slot freed by this
  // cycle's issue is not reused until the next cycle.
  always_comb begin
    alloc_oh   = '0;
    slot_found = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      if (!valid[d] && !slot_found) begin
        alloc_oh[d] = 1'b1;
        slot_found  = 1'b1;
      end
    end
  end

  // CDB tag match for resident entries (wakeup) and for the incoming instruction (bypass).
  always_comb begin
    bp_hit = '0;
    bp_val = '0;
    for (int d = 0; d < DEPTH; d++) begin
      wk_hit[d] = '0;
      wk_val[d] = '0;
    end
    for (int j = 0; j < N_OPERANDS; j++) begin
      for (int i = 0; i < CDB_SIZE; i++) begin
        if (cdb_valid[i] && cdb_tag[i*TAG_WIDTH +: TAG_WIDTH] == alloc_tag[j*TAG_WIDTH +: TAG_WIDTH]) begin
          bp_hit[j] = 1'b1;
          bp_val[j*DATA_WIDTH +: DATA_WIDTH] = bp_val[j*DATA_WIDTH +: DATA_WIDTH]
                                             | cdb_value[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int d = 0; d < DEPTH; d++) begin
          if (cdb_valid[i] && cdb_tag[i*TAG_WIDTH +: TAG_WIDTH] == tag[d][j*TAG_WIDTH +: TAG_WIDTH]) begin
            wk_hit[d][j] = 1'b1;
            wk_val[d][j*DATA_WIDTH +: DATA_WIDTH] = wk_val[d][j*DATA_WIDTH +: DATA_WIDTH]
                                                  | cdb_value[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      count <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        pay[d]   <= '0;
        opnd[d]  <= '0;
        tag[d]   <= '0;
        rdy[d]   <= '0;
        older[d] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      count <= '0;
    end else begin
      for (int d = 0; d < DEPTH; d++) begin
        if (alloc_fire && alloc_oh[d]) begin
          valid[d] <= 1'b1;
          pay[d]   <= alloc_payload;
          tag[d]   <= alloc_tag;
          // New entry is younger than everything else.
          older[d] <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            if (i != d) begin
              older[i][d] <= 1'b1;
            end
          end
          for (int j = 0; j < N_OPERANDS; j++) begin
            if (alloc_rdy[j]) begin
              opnd[d][j*DATA_WIDTH +: DATA_WIDTH] <= alloc_opnd[j*DATA_WIDTH +: DATA_WIDTH];
              rdy[d][j] <= 1'b1;
            end else if (bp_hit[j]) begin
              opnd[d][j*DATA_WIDTH +: DATA_WIDTH] <= bp_val[j*DATA_WIDTH +: DATA_WIDTH];
              rdy[d][j] <= 1'b1;
            end else begin
              opnd[d][j*DATA_WIDTH +: DATA_WIDTH] <= '0;
              rdy[d][j] <= 1'b0;
            end
          end
        end else begin
          if (issue_fire && sel[d]) begin
            valid[d] <= 1'b0;
          end
          for (int j = 0; j < N_OPERANDS; j++) begin
            if (valid[d] && !rdy[d][j] && wk_hit[d][j]) begin
              opnd[d][j*DATA_WIDTH +: DATA_WIDTH] <= wk_val[d][j*DATA_WIDTH +: DATA_WIDTH];
              rdy[d][j] <= 1'b1;
            end
          end
        end
      end
      case ({alloc_fire, issue_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_wakeup_queue.sv
// tb/tb_rs_wakeup_queue.sv - self-checking bench for rs_wakeup_queue
module tb_rs_wakeup_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [63:0] alloc_payload;
  logic [63:0] alloc_opnd;
  logic [7:0]  alloc_tag;
  logic [1:0]  alloc_rdy;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_payload;
  logic [63:0] issue_opnd;
  logic [2:0]  count;

  typedef struct packed {
    logic [63:0] pay;
    logic [63:0] op;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rs_wakeup_queue dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_payload (alloc_payload),
    .alloc_opnd    (alloc_opnd),
    .alloc_tag     (alloc_tag),
    .alloc_rdy     (alloc_rdy),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_value     (cdb_value),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_payload (issue_payload),
    .issue_opnd    (issue_opnd),
    .count         (count)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Compare any handshake about to complete against the scoreboard, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (issue_valid && issue_ready && !flush) begin
      chk("sb_has_entry", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("issue_payload", 128'(issue_payload), 128'(e.pay));
        chk("issue_opnd", 128'(issue_opnd), 128'(e.op));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = 2'b00;
    issue_ready = 1'b0;
  endtask

  task automatic alloc(input logic [63:0] p, input logic [3:0] t1, input logic [3:0] t0,
                       input logic [1:0] r, input logic [31:0] v1, input logic [31:0] v0);
    alloc_valid   = 1'b1;
    alloc_payload = p;
    alloc_tag     = {t1, t0};
    alloc_rdy     = r;
    alloc_opnd    = {v1, v0};
  endtask

  task automatic cdb(input int ch, input logic [3:0] t, input logic [31:0] v);
    cdb_valid[ch]          = 1'b1;
    cdb_tag[ch*4 +: 4]     = t;
    cdb_value[ch*32 +: 32] = v;
  endtask

  task automatic push(input logic [63:0] p, input logic [31:0] v1, input logic [31:0] v0);
    exp_t e;
    e.pay = p;
    e.op  = {v1, v0};
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    alloc_payload = '0;
    alloc_opnd    = '0;
    alloc_tag     = '0;
    alloc_rdy     = '0;
    cdb_tag       = '0;
    cdb_value     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_alloc_ready", 128'(alloc_ready), 128'd1);
    chk("rst_issue_valid", 128'(issue_valid), 128'd0);
    chk("rst_issue_payload", 128'(issue_payload), 128'd0);
    chk("rst_issue_opnd", 128'(issue_opnd), 128'd0);
    rst_n = 1'b1;

    // Wakeup via CDB channel 1
    alloc(64'hA2, 4'd0, 4'd5, 2'b10, 32'h11, 32'h0);
    tick();
    idle();
    chk("t2_count", 128'(count), 128'd1);
    chk("t2_not_ready", 128'(issue_valid), 128'd0);
    cdb(1, 4'd5, 32'hABCD);
    #1;
    chk("t2_no_early_issue", 128'(issue_valid), 128'd0);
    tick();
    idle();
    chk("t2_issue_valid", 128'(issue_valid), 128'd1);
    chk("t2_opnd", 128'(issue_opnd), 128'({32'h11, 32'hABCD}));
    push(64'hA2, 32'h11, 32'hABCD);
    issue_ready = 1'b1;
    tick();
    idle();
    chk("t2_count_after", 128'(count), 128'd0);
    chk("t2_issue_gone", 128'(issue_valid), 128'd0);

    // Bypass in the allocation cycle
    alloc(64'hB3, 4'd0, 4'd3, 2'b10, 32'h22, 32'h0);
    cdb(0, 4'd3, 32'h77);
    tick();
    idle();
    chk("t3_issue_valid", 128'(issue_valid), 128'd1);
    chk("t3_opnd", 128'(issue_opnd), 128'({32'h22, 32'h77}));
    push(64'hB3, 32'h22, 32'h77);
    issue_ready = 1'b1;
    tick();
    idle();
    chk("t3_count_after", 128'(count), 128'd0);

    // Fill, back-pressure, wake entry 2
    for (int k = 0; k < 4; k++) begin
      alloc(64'hC0 + 64'(k), 4'd0, 4'(k + 1), 2'b10, 32'h100 + 32'(k), 32'h0);
      tick();
    end
    idle();
    chk("t4_count_full", 128'(count), 128'd4);
    chk("t4_alloc_ready", 128'(alloc_ready), 128'd0);
    alloc(64'hDEAD, 4'd0, 4'd9, 2'b11, 32'h1, 32'h2);
    tick();
    chk("t4_count_held", 128'(count), 128'd4);
    cdb(0, 4'd3, 32'h333);
    tick();
    cdb_valid = 2'b00;
    chk("t4_issue_valid", 128'(issue_valid), 128'd1);
    chk("t4_still_full", 128'(alloc_ready), 128'd0);
    chk("t4_payload", 128'(issue_payload), 128'(64'hC2));
    idle();
    push(64'hC2, 32'h102, 32'h333);
    issue_ready = 1'b1;
    tick();
    idle();
    chk("t4_count_after", 128'(count), 128'd3);
    chk("t4_alloc_ready_after", 128'(alloc_ready), 128'd1);
    chk("t4_none_ready", 128'(issue_valid), 128'd0);
    flush = 1'b1;
    tick();
    idle();
    chk("t4_flushed", 128'(count), 128'd0);

    // Ordering: B wakes first, older A wakes next cycle
    alloc(64'hAA, 4'd0, 4'd6, 2'b10, 32'hA1, 32'h0);
    tick();
    alloc(64'hBB, 4'd0, 4'd7, 2'b10, 32'hB1, 32'h0);
    tick();
    idle();
    cdb(0, 4'd7, 32'hB0);
    tick();
    idle();
    cdb(1, 4'd6, 32'hA0);
    chk("t5_b_shown", 128'(issue_payload), 128'(64'hBB));
    tick();
    idle();
    chk("t5_a_shown", 128'(issue_payload), 128'(64'hAA));
    push(64'hAA, 32'hA1, 32'hA0);
    push(64'hBB, 32'hB1, 32'hB0);
    issue_ready = 1'b1;
    tick();
    tick();
    idle();
    chk("t5_count_after", 128'(count), 128'd0);

    // Flush with concurrent alloc and issue handshake
    alloc(64'hC1, 4'd0, 4'd0, 2'b11, 32'h1, 32'h2);
    tick();
    alloc(64'hD1, 4'd0, 4'd0, 2'b11, 32'h3, 32'h4);
    tick();
    idle();
    chk("t6_count_two", 128'(count), 128'd2);
    alloc(64'hE1, 4'd0, 4'd0, 2'b11, 32'h5, 32'h6);
    issue_ready = 1'b1;
    flush       = 1'b1;
    tick();
    idle();
    chk("t6_count_zero", 128'(count), 128'd0);
    chk("t6_issue_valid", 128'(issue_valid), 128'd0);
    chk("t6_alloc_ready", 128'(alloc_ready), 128'd1);
    tick();
    chk("t6_not_stored", 128'(count), 128'd0);

    // Asynchronous reset mid-operation
    for (int k = 0; k < 3; k++) begin
      alloc(64'hF0 + 64'(k), 4'd0, 4'(k + 10), 2'b10, 32'h0, 32'h0);
      tick();
    end
    idle();
    chk("t1_count_three", 128'(count), 128'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_count", 128'(count), 128'd0);
    chk("t1_async_issue_valid", 128'(issue_valid), 128'd0);
    chk("t1_async_alloc_ready", 128'(alloc_ready), 128'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_after_release", 128'(count), 128'd0);

    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
